// File: rtl/axis_width_upsize.sv
// axis_width_upsize: packs RATIO narrow AXI-stream samples into one wide word.
// The first accepted sample of a word lands in lane 0 (LSBs); a frame that
// ends early on tlast is emitted as a partial word with the unused upper lanes
// zeroed. The output beat is fully registered; s_axis_tready is the only
// combinational output.
// Optional feature macro: AXIS_UPSIZE_TKEEP_EN adds m_axis_tkeep (one bit per
// lane, set for lanes that hold a real sample).
module axis_width_upsize #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned RATIO      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH*RATIO-1:0]   m_axis_tdata,
  output logic                          m_axis_tlast
`ifdef AXIS_UPSIZE_TKEEP_EN
  ,
  output logic [RATIO-1:0]              m_axis_tkeep
`endif
);

  localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO;
  localparam int unsigned CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned ACC_LANES = RATIO - 1;
  localparam int unsigned ACC_W     = DATA_WIDTH * ACC_LANES;

  // Reject configurations outside the supported packing range at elaboration.
  if (RATIO < 2 || RATIO > 16) begin : g_bad_ratio
    $error("axis_width_upsize: RATIO must be in 2..16");
  end

  logic [CNT_W-1:0]     cnt;
  logic [ACC_W-1:0]     acc;
  logic                 beat_accept;
  logic                 beat_last_lane;
  logic                 beat_complete;
  logic                 word_drain;
  logic [OUT_WIDTH-1:0] word_c;
`ifdef AXIS_UPSIZE_TKEEP_EN
  logic [RATIO-1:0]     keep_c;
`endif

  // Accept whenever the output register is empty or is draining this cycle.
  assign s_axis_tready  = ~rst & (~m_axis_tvalid | m_axis_tready);
  assign beat_accept    = s_axis_tvalid & s_axis_tready;
  assign beat_last_lane = (cnt == CNT_W'(RATIO - 1));
  assign beat_complete  = beat_accept & (beat_last_lane | s_axis_tlast);
  assign word_drain     = m_axis_tvalid & m_axis_tready;

  // Assemble the candidate output word: held lanes below cnt, the live sample
  // in lane cnt, zero padding above it.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] held;
    if (k < RATIO - 1) begin : g_acc
      assign held = acc[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_top
      assign held = '0;
    end
    assign word_c[k*DATA_WIDTH +: DATA_WIDTH] =
      (cnt == CNT_W'(k)) ? s_axis_tdata :
      ((CNT_W'(k) < cnt) ? held : '0);
`ifdef AXIS_UPSIZE_TKEEP_EN
    assign keep_c[k] = (CNT_W'(k) <= cnt);
`endif
  end

  // Lane counter: advance per accepted beat, restart after a completing beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (beat_complete) begin
      cnt <= '0;
    end else if (beat_accept) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Accumulator: capture non-completing beats into their lane, clear on word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (beat_complete) begin
      acc <= '0;
    end else if (beat_accept) begin
      for (int k = 0; k < int'(ACC_LANES); k++) begin
        if (cnt == CNT_W'(k)) begin
          acc[k*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata;
        end
      end
    end
  end

  // Output register: load on a completing beat, otherwise drop valid on drain
  // while holding payload so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (beat_complete) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= word_c;
      m_axis_tlast  <= s_axis_tlast;
    end else if (word_drain) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_UPSIZE_TKEEP_EN
  // Lane-occupancy mask travels with the word it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tkeep <= '0;
    end else if (beat_complete) begin
      m_axis_tkeep <= keep_c;
    end
  end
`endif

endmodule

// File: doc/axis_width_upsize.md
Name: axis_width_upsize

Overview:
Single-clock AXI-stream width upsizer that packs RATIO narrow samples into one wide word. It sits directly upstream of the dual-clock stream FIFO. It turns 18-bit sample beats in the capture domain into the 72-bit words the FIFO carries across to the processing clock. Frame boundaries are carried on tlast; a partial final word is zero-padded.

Parameters:
DATA_WIDTH, 18, width of one input sample (s_axis_tdata).
RATIO, 4, samples packed per output word; legal range 2..16.
OUT_WIDTH, DATA_WIDTH*RATIO (localparam), width of m_axis_tdata.

Ports:
clk  input  1  single clock for both interfaces.
rst  input  1  reset, synchronous, active-high.
s_axis_tvalid  input  1  input sample valid.
s_axis_tready  output  1  input sample accepted when high with tvalid.
s_axis_tdata  input  DATA_WIDTH  input sample.
s_axis_tlast  input  1  last sample of frame.
m_axis_tvalid  output  1  packed word valid (registered).
m_axis_tready  input  1  downstream ready (FIFO not full).
m_axis_tdata  output  OUT_WIDTH  packed word; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
m_axis_tlast  output  1  word contains final sample of frame.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Single clock domain, no CDC.
- State: lane counter cnt (0..RATIO-1); accumulator acc holding lanes 0..RATIO-2; output register (tdata/tlast/tvalid).
- Reset values, applied at the next clk edge with rst high:
  - cnt=0, acc=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready is forced 0 while rst is high.
- Ready: s_axis_tready = ~rst & (~m_axis_tvalid | m_axis_tready), combinational. No bubble at sustained full rate.
- Input beat accepted (s_tvalid & s_tready):
  - Non-completing beat (cnt<RATIO-1 and tlast=0): acc lane cnt <= tdata; cnt <= cnt+1; output register unchanged unless drained.
  - Completing beat (cnt==RATIO-1 or tlast=1):
    - m_axis_tdata <= acc lanes 0..cnt-1, tdata in lane cnt, zero in lanes above cnt.
    - m_axis_tlast <= s_axis_tlast; m_axis_tvalid <= 1.
    - cnt <= 0; acc <= 0.
- Lane order: first-accepted sample in lane 0 (LSBs).
- Latency: m_axis_tvalid rises one clk after the completing beat is accepted.
- Drain: on m_tvalid & m_tready with no completing beat in the same cycle, m_axis_tvalid <= 0; tdata/tlast hold their values.
- Simultaneous drain and completing beat: new word loaded, m_axis_tvalid stays 1 (back-to-back).
- Stall: while m_axis_tvalid=1 and m_axis_tready=0, s_axis_tready=0. Accumulator is frozen and no input is lost.
- m_axis_tdata and m_axis_tlast are stable while tvalid=1 and tready=0 (AXIS rule).
- tlast at cnt==0 emits a word with only lane 0 populated.
- tlast at cnt==RATIO-1 emits a full word with tlast=1.
- Reset mid-frame: partial accumulator and any pending output word are discarded. No flush and no tlast is generated.
- s_axis_tdata is ignored when not accepted. X on an unaccepted beat must not propagate.

Optional Feature:
AXIS_UPSIZE_TKEEP_EN
- Defined:
  - Adds output port m_axis_tkeep, width RATIO, one bit per lane.
  - Bit k=1 if lane k holds a real sample; loaded with the word; reset value 0.
  - Full word gives all ones; tlast at cnt=c gives (2^(c+1))-1.
- Undefined: port absent; padding lanes are still zero; downstream infers length from frame metadata.

Test Plan:
- Reset then 8 beats 0x1,0x2..0x8, tlast on 8th, m_tready=1 → two words:
  - word 1: lanes {1,2,3,4}, tlast=0.
  - word 2: lanes {5,6,7,8}, tlast=1.
  - each appears one cycle after its 4th beat; s_tready stays 1 throughout.
- 6 beats 0xA..0xF, tlast on 6th → word 1 lanes {A,B,C,D}, tlast=0; word 2 lanes {E,F,0,0}, tlast=1; with _EN, tkeep 4'b1111 then 4'b0011.
- Single beat 0x3FFFF with tlast, cnt=0 → word 0x3FFFF in lane 0, zeros above, tlast=1, tkeep=4'b0001.
- Backpressure:
  - Hold m_tready=0 for 10 cycles after the first word; s_tready=0 for those cycles and m_tdata stable.
  - Release it; the continuous stream of 12 samples is delivered intact in order as 3 words.
- Assert rst after 2 of 4 samples → m_tvalid=0 next cycle. After release, 4 new samples 0x11..0x14 give exactly one word {11,12,13,14}, with no residue from the old samples.
- Random tvalid/tready (50%), 1000 samples, random tlast → scoreboard:
  - order and padding correct.
  - words = Σ ceil(frame_len/RATIO).
  - no beat lost or duplicated.
